multiword_add_sequencer: RTL and testbench
==========================================

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the shared carry-lookahead adder slice (one chunk).
REQ-002 Parameter WORDS, default 4: number of WIDTH-bit chunks per operand; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request holds valid operands.
REQ-006 in_ready  output  1  block can accept a request (high only in IDLE).
REQ-007 op_a  input  WIDTH*WORDS  operand A, chunk 0 = bits [WIDTH-1:0].
REQ-008 op_b  input  WIDTH*WORDS  operand B.
REQ-009 sub  input  1  0 = A+B+c_in, 1 = A-B (two's complement).
REQ-010 c_in  input  1  carry-in for add; ignored when sub=1.
REQ-011 out_valid  output  1  result registers hold a completed result.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 sum  output  WIDTH*WORDS  registered result.
REQ-014 c_out  output  1  carry out of the top chunk (for sub: 1 = no borrow).
REQ-015 ovf  output  1  signed overflow of the full-width operation.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready, latch op_a, op_b (inverted when sub=1), initial carry = sub ? 1 : c_in, chunk index = 0, go to RUN.
REQ-019 RUN: each cycle, one adder slice SHALL add chunk[index] of latched A and B with the carry register; at the edge, write that sum chunk into sum[index], load the carry register with the slice carry-out, increment index.
REQ-020 RUN -> DONE at the edge where index = WORDS-1 is processed; c_out gets that chunk's carry-out; ovf = (A_msb == Beff_msb) & (S_msb != A_msb).
REQ-021 Latency: out_valid SHALL rise exactly WORDS clock edges after the accepting edge (4 for default).
REQ-022 DONE: out_valid=1; sum, c_out, ovf SHALL stay stable until out_valid&out_ready; on that edge go to IDLE.
REQ-023 in_valid during RUN/DONE SHALL be ignored (in_ready=0); no request is dropped silently because in_ready is low.
REQ-024 Back-to-back: a new request SHALL be accepted no earlier than the cycle after result handoff (in_ready rises in the cycle after the out handshake).
REQ-025 op_a/op_b/sub/c_in changes after acceptance SHALL not affect the in-flight result.
REQ-026 sum chunks not yet written in RUN hold prior values; only DONE-state outputs are defined.
REQ-027 Exactly one adder slice instance SHALL exist; no combinational path from in_* to out_*.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, index=0, carry=0, sum=0, c_out=0, ovf=0, out_valid=0, busy=0, in_ready=1 from the next cycle, including mid-RUN or mid-DONE (result discarded).
REQ-029 rst SHALL dominate in_valid and out_ready in the same cycle.

Structure
REQ-030 Shared package SHALL hold the state enum (IDLE/RUN/DONE) and the index width function clog2(WORDS).
REQ-031 Sub-module: one carry_lookahead_adder instance with WIDTH = WIDTH, fed by muxed chunk selects.

Verification (WIDTH=8, WORDS=4)
REQ-032 A=0xFFFFFFFF, B=0x00000001, sub=0, c_in=0 -> sum=0x00000000, c_out=1, ovf=0, out_valid 4 edges after accept.
REQ-033 A=0x7FFFFFFF, B=0x00000001, sub=0 -> sum=0x80000000, c_out=0, ovf=1.
REQ-034 A=0x00000005, B=0x00000007, sub=1 -> sum=0xFFFFFFFE, c_out=0, ovf=0.
REQ-035 A=0x12345678, B=0x11111111, c_in=1, out_ready held low 10 cycles -> sum=0x2345678A stable throughout, then handoff, in_ready=1 next cycle.
REQ-036 rst pulsed at 2nd RUN cycle -> out_valid never rises, all outputs 0, next request A=1,B=2 yields sum=3.
REQ-037 in_valid held high continuously with changing operands -> exactly one accept per result, each result matches its accepted operands.

Source files
------------

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and helpers for the multiword add/subtract sequencer.
package multiword_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width needed to index v items.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_carry_lookahead_adder.sv
// Single WIDTH-bit carry-lookahead adder slice, shared by all chunks.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             acc;
  logic             term;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat OR of generate terms propagated up to it, plus c_in.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    term = 1'b0;
    c[0] = c_in;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      term = c_in;
      for (int unsigned j = 0; j <= i; j++) term = term & p[j];
      acc = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k <= i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign sum   = p ^ c[WIDTH-1:0];
  assign c_out = c[WIDTH];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multiword add/subtract: one shared adder slice walks the operand chunks LSB first.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] op_a,
  input  logic [WIDTH*WORDS-1:0] op_b,
  input  logic                   sub,
  input  logic                   c_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   c_out,
  output logic                   ovf,
  output logic                   busy
);

  localparam int unsigned IDX_W = clog2(WORDS);
  localparam int          N     = WIDTH * WORDS;

  state_t           state_q;
  state_t           state_d;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             c_out_q;
  logic             ovf_q;
  logic [WIDTH-1:0] a_chunk;
  logic [WIDTH-1:0] b_chunk;
  logic [WIDTH-1:0] slice_sum;
  logic             slice_c;
  logic             last;

  assign last = (idx_q == IDX_W'(WORDS - 1));

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*WIDTH +: WIDTH];
        b_chunk = b_q[i*WIDTH +: WIDTH];
      end
    end
  end

  carry_lookahead_adder #(
    .WIDTH(WIDTH)
  ) u_cla (
    .a    (a_chunk),
    .b    (b_chunk),
    .c_in (carry_q),
    .sum  (slice_sum),
    .c_out(slice_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // B is stored already inverted for subtract so RUN is a plain add.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub | c_in;
            idx_q   <= '0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) sum_q[i*WIDTH +: WIDTH] <= slice_sum;
          end
          carry_q <= slice_c;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            c_out_q <= slice_c;
            ovf_q   <= (a_q[N-1] == b_q[N-1]) & (slice_sum[WIDTH-1] != a_q[N-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer at WIDTH=8, WORDS=4.
module tb_multiword_add_sequencer;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         sub;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  multiword_add_sequencer #(
    .WIDTH(WIDTH),
    .WORDS(WORDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .sub      (sub),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    int          hold;
    logic [31:0] exp_sum;
    logic        exp_c;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s, input logic ci);
    wait_ready();
    op_a     = a;
    op_b     = b;
    sub      = s;
    c_in     = ci;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a     = ~a;
    op_b     = ~b;
    sub      = ~s;
    c_in     = ~ci;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start(v.a, v.b, v.sub, v.cin);
    chk("busy_run", 32'(busy), 32'd1);
    chk("in_ready_run", 32'(in_ready), 32'd0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
    chk("latency", 32'(lat), 32'(WORDS));
    chk("sum", sum, v.exp_sum);
    chk("c_out", 32'(c_out), 32'(v.exp_c));
    chk("ovf", 32'(ovf), 32'(v.exp_ovf));
    for (int h = 0; h < v.hold; h++) begin
      in_valid = 1'b1;
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", sum, v.exp_sum);
      chk("hold_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_valid", 32'(out_valid), 32'd0);
    chk("handoff_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sum"}, sum, 32'd0);
    chk({tag, "_c_out"}, 32'(c_out), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] e;
    logic [31:0] a_v;
    logic [31:0] b_v;
    logic        take;
    logic        give;
    int          hs;
    int          acc;
    vec_t        v;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 10, 32'h2345678A, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 0, 32'h00000000, 1'b1, 1'b0};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 0, 32'h00000000, 1'b1, 1'b1};
    vecs[7] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, 0, 32'h00010001, 1'b0, 1'b0};
    vecs[8] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, 2, 32'h00000000, 1'b1, 1'b0};
    vecs[9] = '{32'h00000010, 32'h00000010, 1'b1, 1'b1, 0, 32'h00000000, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    c_in      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_cleared("reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the second RUN cycle, competing with in_valid and out_ready.
    start(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0);
    tick();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_cleared("rst_run");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_run_no_valid", 32'(out_valid), 32'd0);
    end
    v = '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 0, 32'h00000003, 1'b0, 1'b0};
    run_vec(v);

    // Reset while a result waits in DONE.
    start(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1);
    for (int i = 0; i < WORDS; i++) tick();
    chk("pre_rst_done_valid", 32'(out_valid), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_cleared("rst_done");

    // in_valid held high with operands changing every cycle.
    hs       = 0;
    acc      = 0;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 80 && hs < 3; cyc++) begin
      a_v       = 32'h01010101 * 32'(cyc) + 32'h0000000F;
      b_v       = 32'h00FF00FF ^ (32'(cyc) << 3);
      op_a      = a_v;
      op_b      = b_v;
      sub       = 1'b0;
      c_in      = cyc[0];
      out_ready = out_valid;
      take      = in_ready;
      give      = out_valid;
      if (give) begin
        if (q.size() == 0) begin
          chk("stream_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("stream_sum", sum, e[31:0]);
          chk("stream_c_out", 32'(c_out), 32'(e[32]));
        end
        hs++;
      end
      tick();
      if (take) begin
        acc++;
        q.push_back({1'b0, a_v} + {1'b0, b_v} + 33'(cyc[0]));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_results", 32'(hs), 32'd3);
    chk("stream_accepts", 32'(acc), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
